stream_rr_arbiter: RTL and testbench
====================================

// Module: stream_rr_arbiter
// PURPOSE
// Shares one valid/ready stream pipeline (skid buffer -> io block -> reg slice chain)
// among NUM_REQ upstream requesters. Round-robin arbitration with bounded burst hold;
// the output is registered, so the block drops in front of the pipeline's up port.
// It tags each beat with the winning requester index so downstream logic can route responses.
// PARAMETERS
// DW         32  data width of every stream
// NUM_REQ    4   number of requesters, >=2
// BURST_MAX  4   max consecutive beats granted to one requester before forced rotation, >=1
// IDW        derived = max(1,$clog2(NUM_REQ)), width of down_id (localparam)
// PORTS
// clk         in   1            single clock, all state on rising edge
// rst_n       in   1            asynchronous active-low reset
// up_valid    in   NUM_REQ      per-requester valid, bit i = requester i
// up_data     in   NUM_REQ*DW   flat data, requester i at [i*DW +: DW]
// up_ready    out  NUM_REQ      per-requester ready, at most one bit high per cycle
// down_valid  out  1            registered output valid
// down_data   out  DW           registered output data
// down_id     out  IDW          index of requester that sourced down_data
// down_ready  in   1            downstream ready
// BEHAVIOUR
// - Reset (async assert, sync deassert by caller): down_valid=0, down_data=0, down_id=0,
//   state=IDLE, rr_ptr=0, beat_cnt=0. up_ready=0 while rst_n=0.
// - out_free = !down_valid | down_ready. Output reg loads only when out_free & a grant exists.
// - up_ready[i] = out_free & grant[i]; grant is combinational from state, up_valid, rr_ptr.
//   Transfer on requester i = up_valid[i] & up_ready[i]. up_ready never high for an idle requester.
// - Latency 1 cycle: beat accepted at edge N appears on down_* after edge N; full throughput
//   (one beat/cycle) when down_ready stays 1.
// - down_valid/down_data/down_id held stable while down_valid & !down_ready (no change, no drop).
// - States: IDLE (no owner), BURST (owner, beat_cnt = beats taken in current burst).
//   IDLE: pick first i with up_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     On transfer -> BURST, owner=i, beat_cnt=1, rr_ptr=(i+1) mod NUM_REQ.
//     No valid -> stay IDLE.
//   BURST: if up_valid[owner] & beat_cnt<BURST_MAX -> grant owner; on transfer beat_cnt+1.
//     Else (owner dropped valid or beat_cnt==BURST_MAX): re-arbitrate in the SAME cycle as in
//     IDLE from rr_ptr (no bubble); new winner -> beat_cnt=1; nobody valid -> IDLE, beat_cnt=0.
//   If out_free=0, no grant, no state/counter/pointer change.
// - Sole valid requester whose burst expired wins again via the search (it is the only
//   candidate): no bubble, beat_cnt restarts at 1.
// - BURST_MAX=1 degenerates to pure per-beat round robin.
// - beat_cnt width $clog2(BURST_MAX+1); never exceeds BURST_MAX; rr_ptr wraps NUM_REQ-1 -> 0.
// - A requester may deassert up_valid without a transfer; the block tolerates it (owner release).
// - Reset mid-burst: all state and outputs return to reset values immediately; any in-flight
//   beat in the output register is discarded.
// TESTING
// 1 NUM_REQ=4,BURST_MAX=1, all up_valid=1, down_ready=1 -> down_id 0,1,2,3,0,1... one beat/cycle.
// 2 BURST_MAX=4, up_valid=4'b0101 steady, down_ready=1 -> down_id 0,0,0,0,2,2,2,2,0..., no gaps.
// 3 down_valid=1 then down_ready=0 for 5 cycles -> down_data/down_id constant, up_ready=0,
//   beat_cnt/rr_ptr unchanged; resume -> next beat in order, none lost or duplicated.
// 4 Owner 1 drops valid after 2 beats while req 3 valid -> next cycle up_ready=4'b1000, beat_cnt=1.
// 5 Only req 3 valid, data=counter 0..11, BURST_MAX=4 -> 12 consecutive beats 0..11, down_id=3.
// 6 rst_n=0 mid-burst (async, between edges) -> down_valid=0 at once; after release with
//   all valid -> first down_id=0.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready streams into one registered
// output stream, with bounded per-requester bursts and a source id on each beat.
//
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   up_valid     : per-requester valid (bit i = requester i)
//   up_data      : flat data, requester i at [i*DW +: DW]
//   up_ready     : per-requester ready, one-hot or zero
//   down_valid   : registered output valid
//   down_data    : registered output data
//   down_id      : requester index that sourced down_data
//   down_ready   : downstream ready
module stream_rr_arbiter #(
  parameter  int DW        = 32,
  parameter  int NUM_REQ   = 4,
  parameter  int BURST_MAX = 4,
  localparam int IDW       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    up_valid,
  input  logic [NUM_REQ*DW-1:0] up_data,
  output logic [NUM_REQ-1:0]    up_ready,
  output logic                  down_valid,
  output logic [DW-1:0]         down_data,
  output logic [IDW-1:0]        down_id,
  input  logic                  down_ready
);

  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [IDW-1:0]   r_owner;
  logic [IDW-1:0]   w_owner_nx;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   w_ptr_nx;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;

  logic             r_valid;
  logic [DW-1:0]    r_data;
  logic [IDW-1:0]   r_id;

  logic             w_free;
  logic             w_keep;
  logic             w_hit;
  logic             w_gnt;
  logic             w_xfer;
  logic [IDW-1:0]   w_arb_idx;
  logic [IDW-1:0]   w_gnt_idx;
  logic [IDW-1:0]   w_cand [NUM_REQ];

  function automatic int wrap(input int a);
    return (a >= NUM_REQ) ? a - NUM_REQ : a;
  endfunction

  // Candidate k is the k-th requester in search order from r_ptr.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand[k] = IDW'(wrap(int'(r_ptr) + k));
    end
  end

  always_comb begin
    w_hit     = 1'b0;
    w_arb_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_hit && up_valid[w_cand[k]]) begin
        w_hit     = 1'b1;
        w_arb_idx = w_cand[k];
      end
    end
  end

  assign w_free = !r_valid || down_ready;

  // Owner keeps the grant until it idles or exhausts its burst;
  // otherwise the search result takes over in the same cycle.
  assign w_keep = (r_state == S_BURST)
               && up_valid[r_owner]
               && (r_cnt < CW'(BURST_MAX));

  assign w_gnt     = w_keep || w_hit;
  assign w_gnt_idx = w_keep ? r_owner : w_arb_idx;
  assign w_xfer    = w_free && w_gnt;

  always_comb begin
    up_ready = '0;
    if (w_xfer && rst_n) begin
      up_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    if (w_free) begin
      if (w_keep) begin
        w_cnt_nx = r_cnt + CW'(1);
      end else if (w_hit) begin
        w_state_nx = S_BURST;
        w_owner_nx = w_arb_idx;
        w_cnt_nx   = CW'(1);
        w_ptr_nx   = (w_arb_idx == IDW'(NUM_REQ - 1))
                   ? '0
                   : w_arb_idx + IDW'(1);
      end else begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= up_data[w_gnt_idx*DW +: DW];
      r_id    <= w_gnt_idx;
    end else if (down_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign down_valid = r_valid;
  assign down_data  = r_data;
  assign down_id    = r_id;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: vector table, directed
// sequences and a randomized run against a behavioural model.
module tb_stream_rr_arbiter;

  localparam int BM = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [3:0]   a_v;
  logic [127:0] a_d;
  logic [3:0]   a_r;
  logic         a_dv;
  logic [31:0]  a_dd;
  logic [1:0]   a_id;
  logic         a_dr;

  logic [3:0]   b_v;
  logic [127:0] b_d;
  logic [3:0]   b_r;
  logic         b_dv;
  logic [31:0]  b_dd;
  logic [1:0]   b_id;
  logic         b_dr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_rr_arbiter #(
    .DW(32), .NUM_REQ(4), .BURST_MAX(BM)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(a_v), .up_data(a_d),
    .up_ready(a_r),
    .down_valid(a_dv), .down_data(a_dd),
    .down_id(a_id), .down_ready(a_dr)
  );

  stream_rr_arbiter #(
    .DW(32), .NUM_REQ(4), .BURST_MAX(1)
  ) u_rr1 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(b_v), .up_data(b_d),
    .up_ready(b_r),
    .down_valid(b_dv), .down_data(b_dd),
    .down_id(b_id), .down_ready(b_dr)
  );

  typedef struct {
    logic [3:0] v;
    logic       dr;
    logic [3:0] rdy;
    logic       dv;
    logic [1:0] id;
  } vec_t;

  vec_t tbl [12];

  // Reference model state
  int       m_owner;
  int       m_run;
  int       m_ptr;
  bit       m_dv;
  logic [31:0] m_dd;
  int       m_id;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_v = 4'hF;
    b_v = 4'h0;
    a_dr = 1'b1;
    b_dr = 1'b1;
    #1;
    chk("rst_ready", 32'(a_r), 32'h0);
    chk("rst_dv", 32'(a_dv), 32'h0);
    chk("rst_id", 32'(a_id), 32'h0);
    chk("rst_data", a_dd, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a_v = 4'h0;
  endtask

  task automatic set_const_data();
    for (int i = 0; i < 4; i++) begin
      a_d[i*32 +: 32] = 32'hA0 + 32'(i);
      b_d[i*32 +: 32] = 32'hB0 + 32'(i);
    end
  endtask

  // Grant by the arbitration rules: continuing owner first,
  // otherwise first valid requester in circular order from ptr.
  function automatic int m_pick(input logic [3:0] v);
    if (m_owner >= 0 && v[m_owner] && m_run < BM) return m_owner;
    for (int k = 0; k < 4; k++) begin
      if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  initial begin
    a_v = '0; a_d = '0; a_dr = 1'b1;
    b_v = '0; b_d = '0; b_dr = 1'b1;

    // Two 4-beat bursts alternating between req 0 and 2,
    // then a one-cycle stall
    tbl[0]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[2]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[3]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[4]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd0};
    tbl[5]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[6]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[8]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2};
    tbl[9]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[10] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[11] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};

    set_const_data();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      a_v  = tbl[c].v;
      a_dr = tbl[c].dr;
      #1;
      chk($sformatf("tbl%0d_ready", c), 32'(a_r), 32'(tbl[c].rdy));
      chk($sformatf("tbl%0d_dv", c), 32'(a_dv), 32'(tbl[c].dv));
      if (tbl[c].dv) begin
        chk($sformatf("tbl%0d_id", c), 32'(a_id), 32'(tbl[c].id));
        chk($sformatf("tbl%0d_data", c), a_dd, 32'hA0 + 32'(tbl[c].id));
      end
      @(negedge clk);
    end

    // BURST_MAX=1: pure per-beat round robin
    do_reset();
    b_v = 4'hF;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk("rr1_ready", 32'(b_r), 32'(4'b0001 << (c % 4)));
      if (c > 0) begin
        chk("rr1_dv", 32'(b_dv), 32'h1);
        chk("rr1_id", 32'(b_id), 32'((c - 1) % 4));
        chk("rr1_data", b_dd, 32'hB0 + 32'((c - 1) % 4));
      end
      @(negedge clk);
    end
    b_v = 4'h0;

    // Stall: output held, nothing granted, burst count preserved
    do_reset();
    a_d[64 +: 32] = 32'h22;
    a_v = 4'b0101;
    a_d[0 +: 32] = 32'd0;
    #1; chk("st_r0", 32'(a_r), 32'h1);
    @(negedge clk);
    a_d[0 +: 32] = 32'd1;
    #1; chk("st_r1", 32'(a_r), 32'h1);
    @(negedge clk);
    a_d[0 +: 32] = 32'd2;
    a_dr = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("st_hold_r", 32'(a_r), 32'h0);
      chk("st_hold_dv", 32'(a_dv), 32'h1);
      chk("st_hold_id", 32'(a_id), 32'h0);
      chk("st_hold_d", a_dd, 32'd1);
      @(negedge clk);
    end
    a_dr = 1'b1;
    #1;
    chk("st_res_r", 32'(a_r), 32'h1);
    chk("st_res_d", a_dd, 32'd1);
    @(negedge clk);
    a_d[0 +: 32] = 32'd3;
    #1;
    chk("st_b3_r", 32'(a_r), 32'h1);
    chk("st_b3_d", a_dd, 32'd2);
    chk("st_b3_id", 32'(a_id), 32'h0);
    @(negedge clk);
    #1;
    chk("st_b4_r", 32'(a_r), 32'h4);
    chk("st_b4_d", a_dd, 32'd3);
    chk("st_b4_id", 32'(a_id), 32'h0);
    @(negedge clk);
    #1;
    chk("st_sw_id", 32'(a_id), 32'h2);
    chk("st_sw_d", a_dd, 32'h22);

    // Owner 1 drops valid after two beats; req 3 takes over
    set_const_data();
    do_reset();
    a_v = 4'b1010;
    #1; chk("od_r0", 32'(a_r), 32'h2);
    @(negedge clk);
    #1; chk("od_r1", 32'(a_r), 32'h2);
    @(negedge clk);
    a_v = 4'b1000;
    #1;
    chk("od_r2", 32'(a_r), 32'h8);
    chk("od_id2", 32'(a_id), 32'h1);
    @(negedge clk);
    a_v = 4'b1001;
    for (int c = 3; c < 7; c++) begin
      #1;
      chk("od_r", 32'(a_r), (c < 6) ? 32'h8 : 32'h1);
      chk("od_id", 32'(a_id), 32'h3);
      @(negedge clk);
    end
    #1; chk("od_id7", 32'(a_id), 32'h0);

    // Sole requester: burst expiry costs no bubble
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      if (c < 12) begin
        a_v = 4'b1000;
        a_d[96 +: 32] = 32'(c);
      end else begin
        a_v = 4'b0000;
      end
      #1;
      if (c < 12) chk("solo_r", 32'(a_r), 32'h8);
      if (c > 0) begin
        chk("solo_dv", 32'(a_dv), 32'h1);
        chk("solo_d", a_dd, 32'(c - 1));
        chk("solo_id", 32'(a_id), 32'h3);
      end
      @(negedge clk);
    end

    // Asynchronous reset mid-burst
    set_const_data();
    do_reset();
    a_v = 4'hF;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_dv", 32'(a_dv), 32'h0);
    chk("ar_r", 32'(a_r), 32'h0);
    chk("ar_id", 32'(a_id), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1; chk("ar_r0", 32'(a_r), 32'h1);
    @(negedge clk);
    #1;
    chk("ar_dv1", 32'(a_dv), 32'h1);
    chk("ar_id1", 32'(a_id), 32'h0);

    // Randomized run against the model
    do_reset();
    m_owner = -1; m_run = 0; m_ptr = 0;
    m_dv = 1'b0; m_dd = '0; m_id = 0;
    for (int c = 0; c < 600; c++) begin
      int  g;
      bit  free;
      bit  keep;
      logic [3:0] er;
      a_v  = 4'($urandom_range(0, 15));
      a_dr = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) a_d[i*32 +: 32] = $urandom;
      #1;
      free = !m_dv || a_dr;
      keep = m_owner >= 0 && a_v[m_owner] && m_run < BM;
      g    = free ? m_pick(a_v) : -1;
      er   = (g >= 0) ? 4'(1 << g) : 4'h0;
      chk("rnd_ready", 32'(a_r), 32'(er));
      chk("rnd_dv", 32'(a_dv), 32'(m_dv));
      if (m_dv) begin
        chk("rnd_data", a_dd, m_dd);
        chk("rnd_id", 32'(a_id), 32'(m_id));
      end
      if (g >= 0) begin
        if (keep) begin
          m_run++;
        end else begin
          m_owner = g;
          m_run   = 1;
          m_ptr   = (g + 1) % 4;
        end
        m_dv = 1'b1;
        m_dd = a_d[g*32 +: 32];
        m_id = g;
      end else if (free) begin
        m_owner = -1;
        m_run   = 0;
        m_dv    = 1'b0;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
